// File: rtl/decode_stream_sequencer_if.sv
// Job, memory, mask, decoder and output signals of the decode stream sequencer.
// The err signal exists only when DECODE_SEQ_UNDERFLOW_CHECK_EN is defined.
interface decode_stream_sequencer_if #(
    parameter int IO_DATA_WIDTH = 8,
    parameter int MEM_BW        = 128,
    parameter int ADDR_W        = 16
);
    localparam int MASK_W = 2 * IO_DATA_WIDTH;

    logic              start;
    logic [ADDR_W-1:0] base_addr;
    logic [15:0]       num_words;
    logic [15:0]       num_blocks;
    logic              busy;
    logic              done;
    logic              mem_re;
    logic [ADDR_W-1:0] mem_addr;
    logic [MEM_BW-1:0] mem_rdata;
    logic              mask_valid;
    logic [MASK_W-1:0] mask;
    logic              mask_ready;
    logic              dec_ce;
    logic [MASK_W-1:0] dec_mask;
    logic [MEM_BW-1:0] dec_data;
    logic              out_valid;
    logic              out_ready;
`ifdef DECODE_SEQ_UNDERFLOW_CHECK_EN
    logic              err;
`endif

    // slave: the sequencer itself; master: the job/memory/consumer side.
    modport slave (
        input  start, base_addr, num_words, num_blocks, mem_rdata,
        input  mask_valid, mask, out_ready,
`ifdef DECODE_SEQ_UNDERFLOW_CHECK_EN
        output err,
`endif
        output busy, done, mem_re, mem_addr, mask_ready,
        output dec_ce, dec_mask, dec_data, out_valid
    );

    modport master (
        output start, base_addr, num_words, num_blocks, mem_rdata,
        output mask_valid, mask, out_ready,
`ifdef DECODE_SEQ_UNDERFLOW_CHECK_EN
        input  err,
`endif
        input  busy, done, mem_re, mem_addr, mask_ready,
        input  dec_ce, dec_mask, dec_data, out_valid
    );
endinterface

// File: rtl/decode_stream_sequencer.sv
// Fetches packed compressed activation words, realigns each variable-length payload
// MSB-first and pulses the decoder CE per block. Optional: DECODE_SEQ_UNDERFLOW_CHECK_EN.
module decode_stream_sequencer #(
    parameter int IO_DATA_WIDTH = 8,
    parameter int MEM_BW        = 128,
    parameter int ADDR_W        = 16
) (
    input  logic clk,
    input  logic rst,
    decode_stream_sequencer_if.slave bus
);
    localparam int MASK_W = 2 * IO_DATA_WIDTH;
    localparam int BUF_W  = 2 * MEM_BW;
    localparam int FILL_W = $clog2(BUF_W + 1);
    localparam int LEN_W  = $clog2(MEM_BW + 1);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_RUN   = 2'd1;
    localparam logic [1:0] S_DRAIN = 2'd2;

    logic [1:0]        state_q, state_d;
    logic [BUF_W-1:0]  buf_q, buf_d;
    logic [FILL_W-1:0] fill_q, fill_d;
    logic [ADDR_W-1:0] base_q, base_d, issued_q, issued_d;
    logic [15:0]       words_left_q, words_left_d, blocks_left_q, blocks_left_d;
    logic              inflight_q, inflight_d, out_valid_q, out_valid_d, done_q, done_d;

    logic [LEN_W-1:0]  set_cnt, pay_len, used_len;
    logic [MEM_BW-1:0] len_mask;
    logic              fire, issue, append, drain_hs;

    always_comb begin
        set_cnt = '0;
        for (int i = 0; i < MASK_W; i++)
            set_cnt = set_cnt + {{(LEN_W-1){1'b0}}, bus.mask[i]};
    end
    assign pay_len  = set_cnt * LEN_W'(IO_DATA_WIDTH);
    assign len_mask = ~({MEM_BW{1'b1}} >> pay_len);

    assign fire = !rst && state_q == S_RUN && bus.mask_valid
                  && fill_q >= FILL_W'(pay_len) && (!out_valid_q || bus.out_ready);
    assign issue = !rst && state_q == S_RUN && words_left_q != 16'd0 && !inflight_q
                   && fill_q <= FILL_W'(MEM_BW);
    assign append   = inflight_q;
    assign drain_hs = !rst && state_q == S_DRAIN && out_valid_q && bus.out_ready;

`ifdef DECODE_SEQ_UNDERFLOW_CHECK_EN
    logic err_q, err_d, underflow;
    assign underflow = !rst && state_q == S_RUN && words_left_q == 16'd0 && !inflight_q
                       && bus.mask_valid && fill_q < FILL_W'(pay_len);
    assign bus.err   = err_q;
    assign bus.done  = !rst && (done_q || drain_hs || underflow);
`else
    assign bus.done  = !rst && (done_q || drain_hs);
`endif

    always_comb begin
        state_d       = state_q;
        base_d        = base_q;
        issued_d      = issued_q;
        words_left_d  = words_left_q;
        blocks_left_d = blocks_left_q;
        inflight_d    = inflight_q;
        done_d        = 1'b0;
`ifdef DECODE_SEQ_UNDERFLOW_CHECK_EN
        err_d         = err_q;
`endif
        // Consume first, then land returning data right behind the surviving bits.
        used_len = fire ? pay_len : '0;
        buf_d    = buf_q << used_len;
        fill_d   = fill_q - FILL_W'(used_len);
        if (append) begin
            buf_d      = buf_d | ({bus.mem_rdata, {MEM_BW{1'b0}}} >> fill_d);
            fill_d     = fill_d + FILL_W'(MEM_BW);
            inflight_d = 1'b0;
        end
        if (fire)               out_valid_d = 1'b1;
        else if (bus.out_ready) out_valid_d = 1'b0;
        else                    out_valid_d = out_valid_q;

        case (state_q)
            S_IDLE: if (bus.start) begin
                base_d        = bus.base_addr;
                issued_d      = '0;
                words_left_d  = bus.num_words;
                blocks_left_d = bus.num_blocks;
                buf_d         = '0;
                fill_d        = '0;
`ifdef DECODE_SEQ_UNDERFLOW_CHECK_EN
                err_d         = 1'b0;
`endif
                if (bus.num_blocks == 16'd0) done_d  = 1'b1;
                else                         state_d = S_RUN;
            end
            S_RUN: begin
                if (issue) begin
                    inflight_d   = 1'b1;
                    words_left_d = words_left_q - 16'd1;
                    issued_d     = issued_q + ADDR_W'(1);
                end
                if (fire) begin
                    blocks_left_d = blocks_left_q - 16'd1;
                    if (blocks_left_q == 16'd1) state_d = S_DRAIN;
                end
`ifdef DECODE_SEQ_UNDERFLOW_CHECK_EN
                if (underflow) begin
                    err_d   = 1'b1;
                    state_d = S_IDLE;
                end
`endif
            end
            S_DRAIN: if (drain_hs) state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= S_IDLE;
            buf_q         <= '0;
            fill_q        <= '0;
            base_q        <= '0;
            issued_q      <= '0;
            words_left_q  <= '0;
            blocks_left_q <= '0;
            inflight_q    <= 1'b0;
            out_valid_q   <= 1'b0;
            done_q        <= 1'b0;
`ifdef DECODE_SEQ_UNDERFLOW_CHECK_EN
            err_q         <= 1'b0;
`endif
        end else begin
            state_q       <= state_d;
            buf_q         <= buf_d;
            fill_q        <= fill_d;
            base_q        <= base_d;
            issued_q      <= issued_d;
            words_left_q  <= words_left_d;
            blocks_left_q <= blocks_left_d;
            inflight_q    <= inflight_d;
            out_valid_q   <= out_valid_d;
            done_q        <= done_d;
`ifdef DECODE_SEQ_UNDERFLOW_CHECK_EN
            err_q         <= err_d;
`endif
        end
    end

    assign bus.busy       = state_q != S_IDLE;
    assign bus.mem_re     = issue;
    assign bus.mem_addr   = base_q + issued_q;
    assign bus.mask_ready = fire;
    assign bus.dec_ce     = fire;
    assign bus.dec_mask   = fire ? bus.mask : '0;
    assign bus.dec_data   = fire ? (buf_q[BUF_W-1 -: MEM_BW] & len_mask) : '0;
    assign bus.out_valid  = out_valid_q;
endmodule

// File: doc/decode_stream_sequencer.md
# decode_stream_sequencer

Sequencer that feeds the bit-plane activation `decoder` from compressed activation memory. Compressed payloads are variable length (8 bits per set mask bit, 0–128 bits) and packed back-to-back across `MEM_BW`-bit memory words. The block fetches words, realigns each payload MSB-first, and pulses the decoder's `CE` once per block. It also paces decoding against downstream backpressure. It sits between the activation SRAM, the mask stream, and the decoder instance feeding the PE array.

## Interface
- `IO_DATA_WIDTH`, 8, activation width; mask width is `2*IO_DATA_WIDTH` (16).
- `MEM_BW`, 128, memory word and decoder payload width.
- `ADDR_W`, 16, memory address width.
- Clock and reset: one clock; reset is synchronous and active-high.
- `clk` in 1: sole clock, rising edge.
- `rst` in 1: synchronous, active-high reset.
- `start` in 1: one-cycle request; sampled only in IDLE.
- `base_addr` in `ADDR_W`: first compressed word address, latched at `start`.
- `num_words` in 16: compressed words to fetch, latched at `start`.
- `num_blocks` in 16: blocks to decode, latched at `start`.
- `busy` out 1: high outside IDLE.
- `done` out 1: one-cycle pulse at job end.
- `mem_re` out 1: read strobe.
- `mem_addr` out `ADDR_W`: read address.
- `mem_rdata` in `MEM_BW`: read data, valid exactly 1 cycle after `mem_re`.
- `mask_valid` in 1, `mask` in 16, `mask_ready` out 1: per-block mask stream; a transfer occurs when valid and ready are both high.
- `dec_ce` out 1: decoder clock enable.
- `dec_mask` out 16: decoder mask.
- `dec_data` out `MEM_BW`: decoder input; payload is MSB-aligned and bits below the payload length are zero.
- `out_valid` out 1, `out_ready` in 1: qualifies the decoder's registered `decoded` output to the consumer.

## Operation
- **States:** IDLE, RUN, DRAIN.
  - IDLE → RUN on `start`. If `num_blocks==0`, go instead IDLE → IDLE and pulse `done` the next cycle with no reads.
  - RUN → DRAIN when the last block fires.
  - DRAIN → IDLE when the last `out_valid && out_ready` handshake occurs; `done` pulses in that same cycle.
- **Bit buffer:** `2*MEM_BW` bits with `fill` 0..256; valid bits are left-justified.
- **Payload length:** `L = 8*popcount(mask)`.
- **Read issue:** in RUN, when `words_left>0`, no read is in flight, and `fill<=MEM_BW`.
  - Assert `mem_re` with `mem_addr = base_addr + words_issued`.
  - At most one read is outstanding.
- **Fire condition:** RUN and `mask_valid` and `fill>=L` and output slot free.
  - Output slot free means `!out_valid || out_ready`.
  - On fire: `dec_ce=1`, `mask_ready=1`, `dec_mask=mask`, `dec_data` = top `L` bits of the buffer with zeros below.
  - Then shift the buffer left by `L` and set `fill -= L`.
  - `mask_ready` equals `dec_ce`; a mask is never consumed without a fire.
- **Append:** returned data is written at bit offset `fill - L_fired` from the top. When append and consume happen in the same cycle, `fill_next = fill - L + MEM_BW`.
- **Zero-mask blocks** (`L=0`) fire without needing buffered bits; the decoder outputs all zeros.
- **Output flag:** `out_valid` sets the cycle after `dec_ce` and clears on handshake unless another fire occurred.
- **Overlap:** fire is allowed in the same cycle as a handshake.
- **Ignored / discarded input:**
  - `start` while busy is ignored.
  - Leftover buffer bits at job end are discarded.
  - Words beyond what is needed are still fetched (`num_words` is authoritative).

## Timing
- **Reset values:** `busy`, `done`, `mem_re`, `dec_ce`, `mask_ready` and `out_valid` are 0; `mem_addr`, `dec_mask` and `dec_data` are 0.
- **Reset contents:** `fill`, all counters and the in-flight flag are cleared.
- **Reset mid-job:** returns to IDLE next cycle. Any read data returning after reset is dropped; no `done` pulse.
- **Job-start latency:**
  - `start` at cycle 0 → `mem_re` at cycle 1.
  - Data is appended at the end of cycle 2.
  - First `dec_ce` no earlier than cycle 3.
  - `out_valid` one cycle after `dec_ce`.
- **Throughput:** at most one read per 2 cycles; one block per cycle when buffered bits suffice.
- **Stalls:** `out_ready` low with `out_valid` high blocks further fires; `decoded` holds because `CE` stays low.

## Configuration
- `DECODE_SEQ_UNDERFLOW_CHECK_EN` defined:
  - Adds output `err` (1 bit, sticky, cleared by `rst` or `start`).
  - Triggers when, in RUN, `words_left==0` with no read in flight, `mask_valid=1` and `fill<L`.
  - On trigger: set `err`, pulse `done`, return to IDLE.
- Undefined: no `err` port; the same condition stalls in RUN until `rst`.

## Test plan
- Job of 2 dense blocks (mask `16'hFFFF`), `num_words=2`, `out_ready=1` → two `dec_ce` pulses, `dec_data` equal to each word, one `done`.
- Masks `16'h000F` and `16'h0F00` (32 bits each) plus `16'h00FF` (64 bits), `num_words=1` → the three payloads are bit-exact slices [127:96], [95:64], [63:0] of the word.
- Payload straddling words: masks `16'h0FFF` (96 bits) then `16'h00FF` (64 bits), `num_words=2` → second `dec_data` top 64 bits = word0[31:0] followed by word1[127:96].
- `out_ready` held low 5 cycles after the first output → no `dec_ce` during the stall, `decoded` stable, processing resumes the cycle `out_ready` rises.
- `num_blocks=0` → `done` 1 cycle after `start`, no `mem_re`. Mask `16'h0000` block → `dec_ce` with no read consumed.
- `rst` asserted in the cycle after `mem_re` → next cycle IDLE, `busy=0`, returned data ignored. A new job then decodes correctly. With the macro defined, `num_words=0` plus a dense mask → `err=1`, `done` pulse.
